// File: rtl/alu_issue_buffer.sv
// -----------------------------------------------------------------------------
// alu_issue_buffer
//
// Issue stage sitting directly in front of the execute ALU. Operand pairs and
// an op code arrive from decode/register-read over a valid/ready handshake and
// are queued in a small FIFO. The head entry is driven to the ALU and held
// stable until the downstream stage consumes it with out_valid/out_ready.
// Multiply ops (ALUop 3'b111) are held back for MUL_HOLD cycles before
// out_valid rises, giving the combinational multiplier path time to settle.
//
// Parameters
//   n         MSB index of operand data (operands are n+1 bits wide)
//   DEPTH     FIFO entries, power of two, >= 2
//   MUL_HOLD  settle cycles in front of a multiply op (0 = no delay)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_valid   upstream entry valid
//   in_ready   buffer can accept an entry (equals !full)
//   in0_i      operand 0 from upstream
//   in1_i      operand 1 from upstream
//   ALUop_i    op code from upstream
//   in0        head operand 0 to the ALU (zero when empty)
//   in1        head operand 1 to the ALU (zero when empty)
//   ALUop      head op code to the ALU (zero when empty)
//   out_valid  head entry is presented and settled
//   out_ready  downstream consumes the head this cycle
//   count      current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module alu_issue_buffer #(
    parameter int n        = 31,
    parameter int DEPTH    = 4,
    parameter int MUL_HOLD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [n:0]               in0_i,
    input  logic [n:0]               in1_i,
    input  logic [2:0]               ALUop_i,
    output logic [n:0]               in0,
    output logic [n:0]               in1,
    output logic [2:0]               ALUop,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int         PW      = $clog2(DEPTH);
    localparam int         CW      = (MUL_HOLD > 1) ? $clog2(MUL_HOLD) : 1;
    localparam logic [2:0] OP_MUL  = 3'b111;
    localparam bit         HOLD_EN = (MUL_HOLD > 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0]   rd_ptr_inc;
    logic [PW:0]     count_reg, count_next;
    logic [CW-1:0]   settle_reg, settle_next;

    logic [n:0]      mem_in0 [DEPTH];
    logic [n:0]      mem_in1 [DEPTH];
    logic [2:0]      mem_op  [DEPTH];

    logic            full, empty, push, pop;
    logic [2:0]      next_op;

    assign full      = (count_reg == (PW+1)'(DEPTH));
    assign empty     = (count_reg == '0);
    assign in_ready  = !full;
    assign out_valid = (state_reg == PRESENT);
    assign push      = in_valid && !full;
    // out_valid is only ever high with a non-empty buffer, so pop never underflows.
    assign pop       = out_valid && out_ready;
    assign count     = count_reg;
    assign rd_ptr_inc = rd_ptr_reg + PW'(1);

    // Head is read combinationally; forcing zeros when empty keeps stale
    // (or never-written) storage off the ALU inputs.
    assign in0   = empty ? '0 : mem_in0[rd_ptr_reg];
    assign in1   = empty ? '0 : mem_in1[rd_ptr_reg];
    assign ALUop = empty ? '0 : mem_op[rd_ptr_reg];

    // Op that becomes the head after a pop. With a single entry left, the only
    // possible successor is the entry being pushed in this same cycle, which is
    // not in storage yet, so bypass it from the input.
    assign next_op = (count_reg > (PW+1)'(1)) ? mem_op[rd_ptr_inc] : ALUop_i;

    // Storage carries no reset: empty gating above hides its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_in0[wr_ptr_reg] <= in0_i;
            mem_in1[wr_ptr_reg] <= in1_i;
            mem_op[wr_ptr_reg]  <= ALUop_i;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (PW+1)'(1);
            2'b01:   count_next = count_reg - (PW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            state_reg  <= IDLE;
            settle_reg <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_inc;
            count_reg  <= count_next;
            state_reg  <= state_next;
            settle_reg <= settle_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        settle_next = settle_reg;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    if (HOLD_EN && (ALUop == OP_MUL)) begin
                        state_next  = SETTLE;
                        settle_next = CW'(MUL_HOLD - 1);
                    end else begin
                        state_next = PRESENT;
                    end
                end
            end
            SETTLE: begin
                if (settle_reg == '0) begin
                    state_next = PRESENT;
                end else begin
                    settle_next = settle_reg - CW'(1);
                end
            end
            PRESENT: begin
                if (pop) begin
                    if (count_next == '0) begin
                        state_next = IDLE;
                    end else if (HOLD_EN && (next_op == OP_MUL)) begin
                        state_next  = SETTLE;
                        settle_next = CW'(MUL_HOLD - 1);
                    end
                end
            end
            default: begin
                state_next  = IDLE;
                settle_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_issue_buffer.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_buffer
//
// Directed bench for alu_issue_buffer with default parameters (n=31, DEPTH=4,
// MUL_HOLD=2). Inputs change 1 ns after a rising edge and outputs are sampled
// at that same point, so each sample reflects the cycle that follows the edge.
// -----------------------------------------------------------------------------
module tb_alu_issue_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in0_i;
    logic [31:0] in1_i;
    logic [2:0]  ALUop_i;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [2:0]  ALUop;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    alu_issue_buffer #(
        .n        (31),
        .DEPTH    (4),
        .MUL_HOLD (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0_i     (in0_i),
        .in1_i     (in1_i),
        .ALUop_i   (ALUop_i),
        .in0       (in0),
        .in1       (in1),
        .ALUop     (ALUop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("[%0t] %s: observed=%0h expected=%0h ok", $time, tag, obs, exp);
        end else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
        in_valid = v;
        in0_i    = a;
        in1_i    = b;
        ALUop_i  = op;
    endtask

    initial begin
        rst       = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'b000);

        // ---------------- reset then idle ----------------
        tick();
        tick();
        check("rst_hold_out_valid", out_valid, 0);
        check("rst_hold_count", count, 0);
        rst = 1'b1;
        #1;
        check("idle_out_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_count", count, 0);
        check("idle_in0", in0, 0);
        check("idle_in1", in1, 0);
        check("idle_aluop", ALUop, 0);

        // ---------------- single add ----------------
        out_ready = 1'b1;
        drive(1'b1, 32'd5, 32'd7, 3'b000);
        tick();                                   // push edge k
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        check("add_cycle_k_out_valid", out_valid, 0);
        check("add_cycle_k_count", count, 1);
        tick();                                   // edge k+1
        check("add_out_valid", out_valid, 1);
        check("add_in0", in0, 5);
        check("add_in1", in1, 7);
        check("add_aluop", ALUop, 3'b000);
        tick();                                   // pop edge
        check("add_after_pop_count", count, 0);
        check("add_after_pop_out_valid", out_valid, 0);
        check("add_after_pop_in0", in0, 0);

        // ---------------- fill / full / wrap ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + i, 32'h110 + i, 3'b000);
            tick();
        end
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);
        drive(1'b1, 32'h14, 32'h114, 3'b000);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        check("full_ignored_count", count, 4);
        check("full_head_in0", in0, 32'h10);
        check("full_out_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check("pop1_head_in0", in0, 32'h11);
        tick();
        check("pop2_head_in0", in0, 32'h12);
        check("pop2_count", count, 2);
        out_ready = 1'b0;
        drive(1'b1, 32'h20, 32'h120, 3'b000);
        tick();
        drive(1'b1, 32'h21, 32'h121, 3'b000);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        check("wrap_full_count", count, 4);
        check("wrap_full_in_ready", in_ready, 0);
        out_ready = 1'b1;
        check("wrap_pop_in0_a", in0, 32'h12);
        tick();
        check("wrap_pop_in0_b", in0, 32'h13);
        tick();
        check("wrap_pop_in0_c", in0, 32'h20);
        check("wrap_pop_in1_c", in1, 32'h120);
        tick();
        check("wrap_pop_in0_d", in0, 32'h21);
        check("wrap_pop_valid_d", out_valid, 1);
        tick();
        check("wrap_empty_count", count, 0);
        check("wrap_empty_out_valid", out_valid, 0);

        // ---------------- multiply settle ----------------
        drive(1'b1, 32'd3, 32'd4, 3'b111);
        tick();                                   // push edge k
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        check("mul_cycle_k_out_valid", out_valid, 0);
        tick();
        check("mul_cycle_k1_out_valid", out_valid, 0);
        tick();
        check("mul_cycle_k2_out_valid", out_valid, 0);
        tick();
        check("mul_cycle_k3_out_valid", out_valid, 1);
        check("mul_in0", in0, 3);
        check("mul_in1", in1, 4);
        check("mul_aluop", ALUop, 3'b111);
        tick();
        check("mul_after_pop_count", count, 0);
        check("mul_after_pop_out_valid", out_valid, 0);

        // ---------------- mixed stream with a stall ----------------
        drive(1'b1, 32'd9, 32'd2, 3'b001);        // sub
        tick();
        check("mix_count1", count, 1);
        check("mix_valid0", out_valid, 0);
        drive(1'b1, 32'd6, 32'd7, 3'b111);        // mul
        tick();
        check("mix_sub_valid", out_valid, 1);
        check("mix_sub_in0", in0, 9);
        check("mix_sub_in1", in1, 2);
        check("mix_sub_aluop", ALUop, 3'b001);
        drive(1'b1, 32'd1, 32'd2, 3'b011);        // or, pushed while sub pops
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        check("mix_settle1_valid", out_valid, 0);
        check("mix_settle1_count", count, 2);
        tick();
        check("mix_settle2_valid", out_valid, 0);
        tick();
        check("mix_mul_valid", out_valid, 1);
        check("mix_mul_in0", in0, 6);
        check("mix_mul_in1", in1, 7);
        check("mix_mul_aluop", ALUop, 3'b111);
        out_ready = 1'b0;
        tick();
        check("mix_stall_valid", out_valid, 1);
        check("mix_stall_in0", in0, 6);
        check("mix_stall_in1", in1, 7);
        check("mix_stall_aluop", ALUop, 3'b111);
        out_ready = 1'b1;
        tick();
        check("mix_or_valid", out_valid, 1);
        check("mix_or_in0", in0, 1);
        check("mix_or_in1", in1, 2);
        check("mix_or_aluop", ALUop, 3'b011);
        check("mix_or_count", count, 1);
        tick();
        check("mix_end_count", count, 0);
        check("mix_end_valid", out_valid, 0);

        // ---------------- async reset mid-flight ----------------
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 32'hB, 3'b111);
        tick();
        drive(1'b1, 32'hC, 32'hD, 3'b000);
        tick();
        drive(1'b1, 32'hE, 32'hF, 3'b000);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        check("ar_pre_count", count, 3);
        check("ar_pre_valid", out_valid, 0);
        #2;
        rst = 1'b0;
        #1;                                       // still well before next edge
        check("ar_now_valid", out_valid, 0);
        check("ar_now_count", count, 0);
        check("ar_now_in_ready", in_ready, 1);
        check("ar_now_in0", in0, 0);
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h55, 32'h66, 3'b010);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        check("ar_new_count", count, 1);
        tick();
        check("ar_new_valid", out_valid, 1);
        check("ar_new_in0", in0, 32'h55);
        check("ar_new_in1", in1, 32'h66);
        check("ar_new_aluop", ALUop, 3'b010);
        tick();
        check("ar_new_end_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_buffer.md
Name: alu_issue_buffer

Overview:
- Operand/op issue stage directly upstream of the execute ALU (n-parameterised, ports [n:0], 3-bit ALUop).
- Accepts operand pairs plus op code from decode/register-read via valid/ready and buffers them in a small FIFO.
- Presents the head entry to the ALU, held stable, with an out_valid/out_ready handshake.
- Multiply ops (ALUop 3'b111) get a programmable settle delay before out_valid rises, so the combinational multiplier path meets timing.

Parameters:
- n, 31, MSB index of data; operand width is n+1 bits.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- MUL_HOLD, 2, settle cycles before presenting a 3'b111 op; 0 means no delay.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  buffer can accept; equals !full.
- in0_i  input  n+1  operand 0.
- in1_i  input  n+1  operand 1.
- ALUop_i  input  3  op code.
- in0  output  n+1  head operand 0 to ALU.
- in1  output  n+1  head operand 1 to ALU.
- ALUop  output  3  head op code to ALU.
- out_valid  output  1  head is presented and settled.
- out_ready  input  1  ALU/result register consumes head this cycle.
- count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=0, async): pointers=0, count=0, FSM=IDLE, settle counter=0, out_valid=0, in0/in1=0, ALUop=3'b000; in_ready=1 once rst deasserts. Reset mid-operation discards all entries with no partial output.
- Push: in_valid && in_ready at a rising edge writes the entry at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop: out_valid && out_ready at a rising edge advances rd_ptr (wraps modulo DEPTH).
- Simultaneous push and pop: count unchanged. When full, push and pop in the same cycle is not possible because in_ready=0 is combinational on full. Pushes while full are ignored.
- count = pushes − pops, range 0..DEPTH. full = (count==DEPTH); empty = (count==0).
- in0/in1/ALUop always drive the head entry (combinational read of rd_ptr). They are zero when empty and never change while out_valid=1 and out_ready=0.
- FSM:
  - IDLE: empty; out_valid=0. On any cycle with count≠0, check the head op: if ALUop==3'b111 and MUL_HOLD>0, go to SETTLE and load counter=MUL_HOLD−1; otherwise go to PRESENT.
  - SETTLE: out_valid=0. Counter decrements each cycle; at 0, go to PRESENT.
  - PRESENT: out_valid=1. On pop:
    - if count after pop is 0, go to IDLE;
    - else if the next head op is 3'b111 and MUL_HOLD>0, go to SETTLE and reload;
    - else stay in PRESENT.
- Latency:
  - Non-multiply entry pushed into an empty buffer at edge k: state becomes PRESENT at edge k+1; out_valid=1 in cycle k+1.
  - Multiply entry pushed at edge k: out_valid first high in cycle k+1+MUL_HOLD.
- Back-to-back non-multiply ops with out_ready=1 sustain one pop per cycle.
- The ALU output is not registered here; the downstream stage captures it on the pop edge.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then release -> out_valid=0, in_ready=1, count=0, in0=in1=0, ALUop=3'b000.
- Single add: push in0=5, in1=7, ALUop=000 with out_ready=1 -> out_valid high exactly one cycle after the push edge with in0=5, in1=7, ALUop=000; count returns to 0 after the pop.
- Fill/full/wrap (DEPTH=4), out_ready=0:
  - push 0x10,0x11,0x12,0x13 -> count=4, in_ready=0; a 5th push of 0x14 is ignored.
  - pop 2 entries, push 0x20 and 0x21 -> entries pop in order 0x12, 0x13, 0x20, 0x21 across the wrap.
- Multiply settle (MUL_HOLD=2): push in0=3, in1=4, ALUop=111 into an empty buffer at edge k -> out_valid=0 in cycles k+1 and k+2, =1 in cycle k+3 with in0=3, in1=4.
- Mixed stream, out_ready=1: push sub(9,2), mul(6,7), or(1,2) -> sub presented first; mul presented after 2 settle cycles; or presented the next cycle; no operand change while out_valid=1 and out_ready=0 (insert a stall cycle).
- Async reset mid-flight: 3 entries queued with state SETTLE; drop rst between edges -> out_valid=0 and count=0 immediately, without waiting for a clock edge; after release, the first new push is presented normally.
